mips_bus_initiator: RTL
=======================

# mips_bus_initiator

Load/store bus initiator for the MIPS CPU datapath: accepts one memory request at a time from the execute/memory stage and drives the CPU memory bus (address, read, write, writedata, byteenable, waitrequest, readdata). It generates big-endian byte lanes for byte, half and word accesses, holds bus requests across waitrequest stalls, and returns aligned, optionally sign-extended load data. It is the initiator end of the same bus the testbench memory models respond on.

## Interface

- No parameters; address and data are fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; sampled only while req_ready=1
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result (byte/half only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  high in IDLE only
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned/illegal request, valid with resp_valid
- address  out  32  word-aligned bus address (bits [1:0] = 00)
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- waitrequest  in  1  responder stall
- writedata  out  32  bus write data
- byteenable  out  4  byteenable[i] enables writedata[8i+7:8i]
- readdata  in  32  bus read data, valid the cycle after read acceptance

## Operation

- States: IDLE, BUS, RDATA, RESP.
- IDLE: req_ready=1. On req_valid: latch request; if aligned and size legal -> BUS, else -> RESP with resp_err=1.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 always illegal. Errors issue no bus cycle.
- Lanes (big-endian), off = addr[1:0]: byte off0->1000, off1->0100, off2->0010, off3->0001; half off0->1100, off2->0011; word->1111. Byteenable is driven for loads and stores.
- Store data: byte replicated to all four lanes ({4{wdata[7:0]}}), half replicated ({2{wdata[15:0]}}), word unchanged.
- BUS: read or write held high, address/writedata/byteenable stable. Acceptance = strobe high and waitrequest=0 at a rising edge. Store -> RESP; load -> RDATA.
- RDATA: read=0; readdata sampled at end of cycle; selected lane extracted (byte off0 = [31:24] ... off3 = [7:0]; half off0 = [31:16], off2 = [15:0]), zero- or sign-extended per req_signed; word passes through -> RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid -> IDLE.
- read and write are never high simultaneously; both are 0 outside BUS.

## Timing

- Reset (synchronous): next edge -> IDLE; read=0, write=0, address=0, writedata=0, byteenable=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after the reset edge.
- Reset mid-transaction (any state): strobes drop at the next edge; the pending response is discarded; no resp_valid.
- Load, zero wait: request edge E0; BUS cycle E0-E1 (accepted at E1); RDATA E1-E2; resp_valid E2-E3. Three cycles request-to-response.
- Store, zero wait: BUS E0-E1, resp_valid E1-E2. Two cycles.
- Error: resp_valid in the cycle after request, with resp_err=1.
- Each waitrequest cycle adds one cycle in BUS; outputs stay constant.
- address, writedata and byteenable hold their last values outside BUS; resp_rdata/resp_err hold after RESP until the next response.
- Back-to-back: next request is accepted in the IDLE cycle after RESP; maximum throughput is one load per 4 cycles.

## Test plan

- Word load from 0xBFC0002C, readdata=0x0000000F, waitrequest=0 -> address=0xBFC0002C, read high for 1 cycle, byteenable=1111, resp_valid 3 cycles after request, resp_rdata=0x0000000F, resp_err=0.
- Byte load at offset 3, readdata=0x123456F0: signed -> byteenable=0001, resp_rdata=0xFFFFFFF0; unsigned -> 0x000000F0.
- Half store to 0xBFC00032, wdata=0x0000ABCD -> address=0xBFC00030, write=1, byteenable=0011, writedata=0xABCDABCD, resp_valid 2 cycles after request.
- Word load with waitrequest high for 5 cycles -> read high for 6 consecutive cycles with stable address; exactly one resp_valid, 8 cycles after request.
- Word load at 0xBFC00002 and size=11 request -> no read/write strobe, resp_valid the next cycle with resp_err=1, resp_rdata=0.
- reset asserted while in BUS with waitrequest=1 -> read=0 the next cycle, req_ready=1, no resp_valid; a following word load completes normally.

Source files
------------

// File: rtl/mips_bus_initiator.sv
// Single-outstanding load/store initiator for the MIPS memory bus with big-endian lanes.
// Latency: load 3 cycles, store 2, error 1, plus one per waitrequest cycle; req_ready only in IDLE.
module mips_bus_initiator (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode: legality, big-endian lane mask and replicated store data.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b1000 >> req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_legal = ~req_addr[0];
        w_be    = req_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_legal = (req_addr[1:0] == 2'b00);
        w_be    = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Load lane extraction; offset 0 is the most significant byte.
  always_comb begin
    w_byte = readdata[31:24];
    case (r_off)
      2'd0:    w_byte = readdata[31:24];
      2'd1:    w_byte = readdata[23:16];
      2'd2:    w_byte = readdata[15:8];
      default: w_byte = readdata[7:0];
    endcase
    w_half = r_off[1] ? readdata[15:0] : readdata[31:16];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_legal ? S_BUS : S_RESP;
      S_BUS:   if (!waitrequest) w_next = r_write ? S_RESP : S_RDATA;
      S_RDATA: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    read       = (r_state == S_BUS) && !r_write;
    write      = (r_state == S_BUS) &&  r_write;
    resp_valid = (r_state == S_RESP);
  end

  // Response registers only change on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_address    <= 32'h0;
      r_writedata  <= 32'h0;
      r_byteenable <= 4'h0;
      r_rdata      <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            if (w_legal) begin
              r_address    <= {req_addr[31:2], 2'b00};
              r_writedata  <= w_wdata;
              r_byteenable <= w_be;
            end else begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest && r_write) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
          end
        end
        S_RDATA: begin
          r_rdata <= w_load;
          r_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
